ysyx_24080006_mdu_ctrl: RTL and testbench
=========================================

Name: ysyx_24080006_mdu_ctrl

Overview:
- Issue/response controller that sits directly upstream of the multi-cycle multiply/divide unit in the EX stage.
- Accepts one RV32M op from the ID/EX handshake, decodes funct3 into the MDU op/sign settings, and holds operands stable for the whole MDU computation.
- Captures the single-cycle MDU result and presents it to writeback through a valid/ready interface.
- Absorbs pipeline flushes while the MDU is busy, and short-circuits repeated identical ops with a one-entry result cache.

Parameters:
- CACHE_EN, 1, enables the one-entry result cache (0: every op goes to the MDU).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill current op (branch mispredict/trap)
- in_valid  in  1  op available from ID/EX
- in_ready  out  1  controller can accept op
- in_funct3  in  3  RV32M funct3
- in_rs1  in  32  operand A
- in_rs2  in  32  operand B
- in_rd  in  5  destination register
- mdu_a  out  32  registered operand A to MDU
- mdu_b  out  32  registered operand B to MDU
- mdu_set  out  mdu_set_t  {mdu_op, signed_a, signed_b} to MDU
- mdu_valid  out  1  request to MDU; held high until the cycle mdu_ready=1, inclusive
- mdu_o  in  32  MDU result, valid only while mdu_ready=1
- mdu_ready  in  1  single-cycle MDU completion
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_rd  out  5  destination of result
- out_data  out  32  result
- busy  out  1  state != IDLE (hazard unit stall)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all operand/result registers 0; cache_valid=0.
  - Outputs: mdu_valid=0, out_valid=0, in_ready=1 after release, busy=0.
  - Reset mid-operation abandons the op. The MDU is reset in the same window by the integrating top.
- Decode funct3 -> (mdu_op, signed_a, signed_b):
  - 000 -> (MULL,1,1); 001 -> (MULH,1,1); 010 -> (MULH,1,0); 011 -> (MULH,0,0)
  - 100 -> (DIV,1,1); 101 -> (DIV,0,0); 110 -> (REM,1,1); 111 -> (REM,0,0)
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - in_ready = ~flush.
  - On in_valid & in_ready: register rs1, rs2, funct3 and rd; mdu_set is driven from these registers.
  - If CACHE_EN, cache_valid and {funct3, rs1, rs2} equal the cache key: load the cached data into the result register and go to RESP (hit). mdu_valid is never asserted.
  - Otherwise go to BUSY.
- BUSY:
  - mdu_valid=1; mdu_a, mdu_b and mdu_set stay constant.
  - On mdu_ready: capture mdu_o into the result register; write the cache (key, data, cache_valid=1); go to RESP.
  - flush (with or without mdu_ready in the same cycle) -> DRAIN, or IDLE if mdu_ready is also 1. The result is discarded and the cache is not written.
- DRAIN:
  - mdu_valid=1 until mdu_ready; mdu_ready -> IDLE. flush is ignored.
  - Required because the MDU has no abort and must be walked back to idle.
- RESP:
  - out_valid = ~flush; out_data and out_rd stay stable while out_ready=0.
  - out_valid & out_ready -> IDLE. flush -> IDLE and the result is dropped.
- Latency:
  - Cache hit: out_valid in the 1st cycle after accept.
  - Miss: out_valid in the cycle after mdu_ready.
  - Next accept: the cycle after the out handshake; no back-to-back issue.
- mdu_valid drops the cycle after mdu_ready, so the MDU returns to idle and does not restart.
- Cache rules:
  - The key includes funct3, so DIV and REM on the same operands miss each other.
  - flush does not invalidate the cache (results are pure functions of the key).
  - With CACHE_EN=0 the cache logic is absent and cache_valid is tied to 0.
- Divide-by-zero and overflow results are produced by the MDU and passed through unchanged.

Decomposition:
- Shared package (ysyx_24080006_pkg):
  - mdu_set_t and the ALU_MULL/MULH/DIV/REM encodings (already present).
  - New mdu_ctrl_fsm_e enum.
  - New funct3 localparams (F3_MUL .. F3_REMU).
- One sub-module: ysyx_24080006_mdu_dec (combinational funct3 -> mdu_set_t). Everything else stays in this module.

Test Plan:
- DIV -7 (0xFFFFFFF9) / 2, rd=5 -> mdu_valid held until mdu_ready; out_data=0xFFFFFFFD, out_rd=5; busy=1 from the cycle after accept until the out handshake.
- Repeat the same DIV -> out_valid exactly 1 cycle after accept; mdu_valid stays 0. Then REM -7/2 -> miss, out_data=0xFFFFFFFF.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 3*-4 -> 0xFFFFFFF4.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/-1 -> 0x80000000.
- flush 3 cycles into BUSY -> state DRAIN; mdu_valid stays 1 until mdu_ready; no out_valid; in_ready=1 the cycle after mdu_ready; a following identical op misses the cache.
- Hold out_ready=0 for 5 cycles in RESP -> out_valid, out_data and out_rd stable; in_ready=0. Then assert reset=0 mid-BUSY -> mdu_valid=0 and out_valid=0 immediately (async); a following identical op misses the cache.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared MDU encodings, controller states and RV32M funct3 codes
package ysyx_24080006_pkg;
  localparam logic [1:0] ALU_MULL = 2'd0;
  localparam logic [1:0] ALU_MULH = 2'd1;
  localparam logic [1:0] ALU_DIV  = 2'd2;
  localparam logic [1:0] ALU_REM  = 2'd3;
  typedef struct packed {
    logic [1:0] mdu_op;
    logic       signed_a;
    logic       signed_b;
  } mdu_set_t;
  typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DRAIN, MC_RESP} mdu_ctrl_fsm_e;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
endpackage

// File: rtl/ysyx_24080006_mdu_dec.sv
// ysyx_24080006_mdu_dec: RV32M funct3 to MDU op/sign settings
module ysyx_24080006_mdu_dec
  import ysyx_24080006_pkg::*;
(
  input  logic [2:0] funct3,
  output mdu_set_t   mdu_set
);
  always_comb begin
    mdu_set.mdu_op   = funct3[2] ? (funct3[1] ? ALU_REM : ALU_DIV) : (funct3 == F3_MUL ? ALU_MULL : ALU_MULH);
    mdu_set.signed_a = funct3[2] ? ~funct3[0] : funct3 != F3_MULHU;
    mdu_set.signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
  end
endmodule

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// ysyx_24080006_mdu_ctrl: RV32M issue/response controller with flush drain and one-entry result cache
module ysyx_24080006_mdu_ctrl
  import ysyx_24080006_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output mdu_set_t    mdu_set,
  output logic        mdu_valid,
  input  logic [31:0] mdu_o,
  input  logic        mdu_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        busy
);
  mdu_ctrl_fsm_e state, state_n;
  logic [31:0] a_q, b_q, res_q, key_a, key_b, cache_data;
  logic [2:0]  f3_q, key_f3;
  logic [4:0]  rd_q;
  logic        cache_valid, accept, hit, done;
  assign in_ready  = (state == MC_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign hit       = cache_valid & (key_f3 == in_funct3) & (key_a == in_rs1) & (key_b == in_rs2);
  assign done      = (state == MC_BUSY) & mdu_ready & ~flush;
  assign mdu_valid = (state == MC_BUSY) | (state == MC_DRAIN);
  assign out_valid = (state == MC_RESP) & ~flush;
  assign busy      = state != MC_IDLE;
  assign mdu_a     = a_q;
  assign mdu_b     = b_q;
  assign out_rd    = rd_q;
  assign out_data  = res_q;
  ysyx_24080006_mdu_dec u_dec (
    .funct3  (f3_q),
    .mdu_set (mdu_set)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= MC_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      MC_IDLE:  state_n = accept ? (hit ? MC_RESP : MC_BUSY) : MC_IDLE;
      MC_BUSY:  state_n = flush ? (mdu_ready ? MC_IDLE : MC_DRAIN) : (mdu_ready ? MC_RESP : MC_BUSY);
      MC_DRAIN: state_n = mdu_ready ? MC_IDLE : MC_DRAIN;
      MC_RESP:  state_n = (flush | out_ready) ? MC_IDLE : MC_RESP;
      default:  state_n = MC_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= in_rs1;
        b_q  <= in_rs2;
        f3_q <= in_funct3;
        rd_q <= in_rd;
      end
      res_q <= (accept & hit) ? cache_data : done ? mdu_o : res_q;
    end
  if (CACHE_EN) begin : g_cache
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        cache_valid <= 1'b0;
        key_f3      <= '0;
        key_a       <= '0;
        key_b       <= '0;
        cache_data  <= '0;
      end else if (done) begin
        cache_valid <= 1'b1;
        key_f3      <= f3_q;
        key_a       <= a_q;
        key_b       <= b_q;
        cache_data  <= mdu_o;
      end
  end else begin : g_nocache
    assign cache_valid = 1'b0;
    assign key_f3      = '0;
    assign key_a       = '0;
    assign key_b       = '0;
    assign cache_data  = '0;
  end
endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// tb_ysyx_24080006_mdu_ctrl: directed self-checking bench for the MDU controller
module tb_ysyx_24080006_mdu_ctrl;
  import ysyx_24080006_pkg::*;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        mdu_ready = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] mdu_o = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready, mdu_valid, out_valid, busy;
  logic [31:0] mdu_a, mdu_b, out_data;
  logic [4:0]  out_rd;
  mdu_set_t    mdu_set;
  int n_cmp = 0;
  int n_err = 0;
  ysyx_24080006_mdu_ctrl #(.CACHE_EN(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .mdu_a     (mdu_a),
    .mdu_b     (mdu_b),
    .mdu_set   (mdu_set),
    .mdu_valid (mdu_valid),
    .mdu_o     (mdu_o),
    .mdu_ready (mdu_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .busy      (busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clock);
    in_valid = 1'b1;
    in_funct3 = f3;
    in_rs1 = a;
    in_rs2 = b;
    in_rd = rd;
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy_idle"}, busy, 0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask
  task automatic run_miss(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input logic [3:0] set);
    issue(tag, f3, a, b, rd);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_mv"}, mdu_valid, 1);
    chk({tag, "_ov_busy"}, out_valid, 0);
    chk({tag, "_mdu_a"}, mdu_a, a);
    chk({tag, "_mdu_b"}, mdu_b, b);
    chk({tag, "_mdu_set"}, mdu_set, set);
    @(negedge clock);
    chk({tag, "_mv_hold"}, mdu_valid, 1);
    chk({tag, "_a_hold"}, mdu_a, a);
    chk({tag, "_set_hold"}, mdu_set, set);
    @(negedge clock);
    mdu_ready = 1'b1;
    mdu_o = res;
    chk({tag, "_mv_done"}, mdu_valid, 1);
    chk({tag, "_ov_done"}, out_valid, 0);
    @(negedge clock);
    mdu_ready = 1'b0;
    mdu_o = 32'hDEAD_BEEF;
    chk({tag, "_mv_drop"}, mdu_valid, 0);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_data"}, out_data, res);
    chk({tag, "_rd"}, out_rd, rd);
    chk({tag, "_busy_resp"}, busy, 1);
    chk({tag, "_rdy_resp"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ov_end"}, out_valid, 0);
    chk({tag, "_rdy_end"}, in_ready, 1);
  endtask
  task automatic run_hit(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res);
    issue(tag, f3, a, b, rd);
    chk({tag, "_mv"}, mdu_valid, 0);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_data"}, out_data, res);
    chk({tag, "_rd"}, out_rd, rd);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_mv_end"}, mdu_valid, 0);
  endtask
  initial begin
    #12;
    chk("rst_mv", mdu_valid, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_a", mdu_a, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rel_rdy", in_ready, 1);
    run_miss("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 4'b1011);
    run_hit("div_hit", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
    run_miss("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 4'b1111);
    run_miss("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 4'b0100);
    run_miss("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 4'b0110);
    run_miss("mul", F3_MUL, 32'd3, 32'hFFFF_FFFC, 5'd3, 32'hFFFF_FFF4, 4'b0011);
    run_miss("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 4'b0111);
    run_miss("divu0", F3_DIVU, 32'h1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 4'b1000);
    run_miss("rem0", F3_REM, 32'h1234, 32'd0, 5'd8, 32'h0000_1234, 4'b1111);
    run_miss("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 4'b1011);
    run_miss("remu", F3_REMU, 32'd7, 32'd2, 5'd11, 32'd1, 4'b1100);
    issue("fl", F3_DIV, 32'd100, 32'd7, 5'd3);
    chk("fl_mv1", mdu_valid, 1);
    @(negedge clock);
    chk("fl_mv2", mdu_valid, 1);
    @(negedge clock);
    flush = 1'b1;
    chk("fl_mv3", mdu_valid, 1);
    chk("fl_rdy3", in_ready, 0);
    @(negedge clock);
    chk("fl_drain_mv", mdu_valid, 1);
    chk("fl_drain_ov", out_valid, 0);
    chk("fl_drain_busy", busy, 1);
    chk("fl_drain_rdy", in_ready, 0);
    @(negedge clock);
    flush = 1'b0;
    mdu_ready = 1'b1;
    mdu_o = 32'd14;
    chk("fl_drain_mv2", mdu_valid, 1);
    chk("fl_drain_ov2", out_valid, 0);
    @(negedge clock);
    mdu_ready = 1'b0;
    chk("fl_idle_rdy", in_ready, 1);
    chk("fl_idle_mv", mdu_valid, 0);
    chk("fl_idle_ov", out_valid, 0);
    chk("fl_idle_busy", busy, 0);
    run_miss("fl_again", F3_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 4'b1011);
    issue("flr", F3_DIVU, 32'd50, 32'd5, 5'd12);
    flush = 1'b1;
    mdu_ready = 1'b1;
    mdu_o = 32'd10;
    chk("flr_mv", mdu_valid, 1);
    @(negedge clock);
    flush = 1'b0;
    mdu_ready = 1'b0;
    chk("flr_busy", busy, 0);
    chk("flr_ov", out_valid, 0);
    chk("flr_mv_end", mdu_valid, 0);
    run_miss("flr_again", F3_DIVU, 32'd50, 32'd5, 5'd12, 32'd10, 4'b1000);
    issue("hold", F3_DIVU, 32'd100, 32'd3, 5'd9);
    @(negedge clock);
    mdu_ready = 1'b1;
    mdu_o = 32'h21;
    @(negedge clock);
    mdu_ready = 1'b0;
    mdu_o = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    in_funct3 = F3_MUL;
    in_rs1 = 32'd1;
    in_rs2 = 32'd1;
    in_rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", out_valid, 1);
      chk("hold_data", out_data, 32'h21);
      chk("hold_rd", out_rd, 5'd9);
      chk("hold_rdy", in_ready, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("hold_ov_last", out_valid, 1);
    @(negedge clock);
    out_ready = 1'b0;
    chk("hold_busy_end", busy, 0);
    issue("rst", F3_MUL, 32'd5, 32'd6, 5'd2);
    chk("rst_mid_mv", mdu_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_mv", mdu_valid, 0);
    chk("rst_async_ov", out_valid, 0);
    chk("rst_async_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    run_miss("rst_hold_op", F3_DIVU, 32'd100, 32'd3, 5'd9, 32'h21, 4'b1000);
    run_miss("rst_again", F3_MUL, 32'd5, 32'd6, 5'd2, 32'd30, 4'b0011);
    issue("rflush", F3_MUL, 32'd5, 32'd6, 5'd13);
    chk("rflush_ov", out_valid, 1);
    chk("rflush_mv", mdu_valid, 0);
    flush = 1'b1;
    #1 chk("rflush_ov_fl", out_valid, 0);
    @(negedge clock);
    flush = 1'b0;
    chk("rflush_busy", busy, 0);
    chk("rflush_ov_end", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
